// File: rtl/sequenciador_movimentos_pkg.sv
`default_nettype none
// ============================================================================
// Package    : sequenciador_movimentos_pkg
// Description: Shared types and constants for the cube-move scheduler. Holds
//              the FSM state encoding, command field widths and the debug
//              code shown for an illegal state.
// Revision   : 1.0 - initial release
// ============================================================================
package sequenciador_movimentos_pkg;

  // Quarter-turn field width (0..3 quarter turns per command)
  localparam int QUARTOS_W = 2;

  // Shared settle/watchdog cycle counter width (covers 100M cycles)
  localparam int CNT_W = 27;

  // db_estado value shown when the state register holds an unused encoding
  localparam logic [3:0] DB_ILEGAL = 4'b1110;

  typedef enum logic [3:0] {
    ST_INICIAL = 4'b0000,
    ST_BUSCA   = 4'b0001,
    ST_DISPARA = 4'b0010,
    ST_ESPERA  = 4'b0011,
    ST_CONTA   = 4'b0100,
    ST_ASSENTA = 4'b0101,
    ST_ERRO    = 4'b1111
  } estado_t;

  // Map the state register onto the 7-segment debug code
  function automatic logic [3:0] db_codigo(input estado_t e);
    case (e)
      ST_INICIAL, ST_BUSCA, ST_DISPARA, ST_ESPERA,
      ST_CONTA, ST_ASSENTA, ST_ERRO: db_codigo = 4'(e);
      default:                       db_codigo = DB_ILEGAL;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sequenciador_movimentos_fila.sv
`default_nettype none
// ============================================================================
// Module     : fila_movimentos
// Description: Synchronous FIFO holding queued move commands. Supports
//              simultaneous push/pop, a flush that empties it in one cycle,
//              and reports full/empty flags and the current fill level.
// Revision   : 1.0 - initial release
// ============================================================================
module fila_movimentos
  import sequenciador_movimentos_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         dado_i,
  output logic [WIDTH-1:0]         dado_o,
  output logic                     cheia_o,
  output logic                     vazia_o,
  output logic [$clog2(DEPTH):0]   nivel_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   NIVEL_MAX = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   NIVEL_UM  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_UM    = PTR_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [PTR_W:0]   nivel_q;

  logic w_push_ok;
  logic w_pop_ok;

  assign cheia_o   = (nivel_q == NIVEL_MAX);
  assign vazia_o   = (nivel_q == '0);
  assign nivel_o   = nivel_q;
  assign dado_o    = mem_q[rd_q];
  assign w_push_ok = push_i & ~cheia_o;
  assign w_pop_ok  = pop_i & ~vazia_o;

  // Pointer and level bookkeeping; flush takes priority over push/pop
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      nivel_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      nivel_q <= '0;
    end else begin
      if (w_push_ok) wr_q <= wr_q + PTR_UM;
      if (w_pop_ok)  rd_q <= rd_q + PTR_UM;
      case ({w_push_ok, w_pop_ok})
        2'b10:   nivel_q <= nivel_q + NIVEL_UM;
        2'b01:   nivel_q <= nivel_q - NIVEL_UM;
        default: nivel_q <= nivel_q;
      endcase
    end
  end

  // Storage array; contents need no reset because the level gates every read
  always_ff @(posedge clock) begin
    if (w_push_ok && !flush_i) mem_q[wr_q] <= dado_i;
  end

endmodule
`default_nettype wire

// File: rtl/sequenciador_movimentos.sv
`default_nettype none
// ============================================================================
// Module     : sequenciador_movimentos
// Description: Move scheduler for the servo_360 units. Queues cube-move
//              commands and runs them one at a time: one start pulse per
//              quarter turn, wait for the servo's pronto, settle after each
//              move. A watchdog traps a servo that never answers.
// Revision   : 1.0 - initial release
// ============================================================================
module sequenciador_movimentos
  import sequenciador_movimentos_pkg::*;
#(
  parameter int N_SERVOS       = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int SETTLE_CYCLES  = 5_000_000,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cmd_valid_i,
  input  logic [$clog2(N_SERVOS)-1:0]   cmd_servo_i,
  input  logic                          cmd_sentido_i,
  input  logic [QUARTOS_W-1:0]          cmd_quartos_i,
  output logic                          cmd_ready_o,
  output logic [N_SERVOS-1:0]           servo_iniciar_o,
  output logic                          servo_sentido_o,
  input  logic [N_SERVOS-1:0]           servo_pronto_i,
  input  logic                          limpa_erro_i,
  output logic                          ocupado_o,
  output logic                          fim_sequencia_o,
  output logic                          erro_timeout_o,
  output logic [$clog2(FIFO_DEPTH):0]   fila_nivel_o,
  output logic [3:0]                    db_estado_o
);

  localparam int SERVO_W = $clog2(N_SERVOS);
  localparam int CMD_W   = SERVO_W + 1 + QUARTOS_W;
  localparam int NIVEL_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0]    SETTLE_FIM  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    TIMEOUT_FIM = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_UM      = CNT_W'(1);
  localparam logic [N_SERVOS-1:0] SERVO_UM    = N_SERVOS'(1);

  // FSM state and the move currently being executed
  estado_t                 estado_q;
  logic [SERVO_W-1:0]      servo_q;
  logic [QUARTOS_W-1:0]    quartos_q;
  logic [QUARTOS_W-1:0]    quarto_q;
  logic [CNT_W-1:0]        ciclos_q;
  logic [N_SERVOS-1:0]     iniciar_q;
  logic                    sentido_q;
  logic                    fim_q;
  logic                    erro_q;

  // Queue interface
  logic [CMD_W-1:0]        w_cmd_in;
  logic [CMD_W-1:0]        w_cabeca;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_flush;
  logic                    w_cheia;
  logic                    w_vazia;
  logic [NIVEL_W-1:0]      w_nivel;

  // Decoded head-of-queue fields
  logic [SERVO_W-1:0]      w_cab_servo;
  logic                    w_cab_sentido;
  logic [QUARTOS_W-1:0]    w_cab_quartos;

  logic                    w_pronto_sel;
  logic                    w_timeout;
  logic [QUARTOS_W-1:0]    w_quarto_prox;

  assign w_cmd_in      = {cmd_servo_i, cmd_sentido_i, cmd_quartos_i};
  assign w_cab_servo   = w_cabeca[CMD_W-1 -: SERVO_W];
  assign w_cab_sentido = w_cabeca[QUARTOS_W];
  assign w_cab_quartos = w_cabeca[QUARTOS_W-1:0];

  // Only the servo that owns the current move may end the wait
  assign w_pronto_sel  = |(servo_pronto_i & (SERVO_UM << servo_q));
  assign w_timeout     = (estado_q == ST_ESPERA) & ~w_pronto_sel & (ciclos_q == TIMEOUT_FIM);
  assign w_quarto_prox = quarto_q + 2'd1;

  // The queue is cleared on the watchdog edge and kept empty while in erro
  assign cmd_ready_o = ~w_cheia & (estado_q != ST_ERRO);
  assign w_push      = cmd_valid_i & cmd_ready_o;
  assign w_pop       = (estado_q == ST_BUSCA);
  assign w_flush     = w_timeout | (estado_q == ST_ERRO);

  fila_movimentos #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fila (
    .clock   (clock),
    .reset   (reset),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .flush_i (w_flush),
    .dado_i  (w_cmd_in),
    .dado_o  (w_cabeca),
    .cheia_o (w_cheia),
    .vazia_o (w_vazia),
    .nivel_o (w_nivel)
  );

  // Move sequencing FSM with its counters and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= ST_INICIAL;
      servo_q   <= '0;
      quartos_q <= '0;
      quarto_q  <= '0;
      ciclos_q  <= '0;
      iniciar_q <= '0;
      sentido_q <= 1'b0;
      fim_q     <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      iniciar_q <= '0;
      fim_q     <= 1'b0;
      case (estado_q)
        ST_INICIAL: begin
          if (!w_vazia) estado_q <= ST_BUSCA;
        end
        ST_BUSCA: begin
          servo_q   <= w_cab_servo;
          sentido_q <= w_cab_sentido;
          quartos_q <= w_cab_quartos;
          quarto_q  <= '0;
          if (w_cab_quartos == '0) begin
            estado_q <= ST_INICIAL;
          end else begin
            estado_q  <= ST_DISPARA;
            iniciar_q <= SERVO_UM << w_cab_servo;
          end
        end
        ST_DISPARA: begin
          ciclos_q <= '0;
          estado_q <= ST_ESPERA;
        end
        ST_ESPERA: begin
          if (w_pronto_sel) begin
            estado_q <= ST_CONTA;
          end else if (ciclos_q == TIMEOUT_FIM) begin
            estado_q <= ST_ERRO;
            erro_q   <= 1'b1;
          end else begin
            ciclos_q <= ciclos_q + CNT_UM;
          end
        end
        ST_CONTA: begin
          quarto_q <= w_quarto_prox;
          if (w_quarto_prox == quartos_q) begin
            estado_q <= ST_ASSENTA;
            ciclos_q <= '0;
          end else begin
            estado_q  <= ST_DISPARA;
            iniciar_q <= SERVO_UM << servo_q;
          end
        end
        ST_ASSENTA: begin
          if (ciclos_q == SETTLE_FIM) begin
            if (w_vazia) begin
              estado_q <= ST_INICIAL;
              fim_q    <= 1'b1;
            end else begin
              estado_q <= ST_BUSCA;
            end
          end else begin
            ciclos_q <= ciclos_q + CNT_UM;
          end
        end
        ST_ERRO: begin
          if (limpa_erro_i) begin
            estado_q <= ST_INICIAL;
            erro_q   <= 1'b0;
          end
        end
        default: begin
          estado_q <= ST_INICIAL;
          erro_q   <= 1'b0;
        end
      endcase
    end
  end

  assign servo_iniciar_o = iniciar_q;
  assign servo_sentido_o = sentido_q;
  assign fim_sequencia_o = fim_q;
  assign erro_timeout_o  = erro_q;
  assign fila_nivel_o    = w_nivel;
  assign db_estado_o     = db_codigo(estado_q);
  assign ocupado_o       = ((estado_q != ST_INICIAL) && (estado_q != ST_ERRO)) || (w_nivel != '0);

endmodule
`default_nettype wire
